// File: rtl/riscv_core_pkg.sv
// -----------------------------------------------------------------------------
// riscv_core_pkg
// Shared definitions for the RISC-V core front end.
//   - instruction / address widths
//   - next-PC select encodings driven by decode
//   - canonical NOP (addi x0, x0, 0)
//   - {pc, instr} entry type carried from fetch to decode
// No ports (package).
// -----------------------------------------------------------------------------
package riscv_core_pkg;

    localparam int XLEN    = 32;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    // Next-PC select from decode. Encodings 2'b10/2'b11 are reserved and
    // behave like sequential fetch.
    typedef enum logic [1:0] {
        NPC_SEQ      = 2'b00,
        NPC_REDIRECT = 2'b01
    } npc_sel_e;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic is_redirect(input logic [1:0] sel);
        return (sel == NPC_REDIRECT);
    endfunction

endpackage

// File: rtl/riscv_core_if_fifo.sv
// -----------------------------------------------------------------------------
// riscv_core_if_fifo
// Two-entry {pc, instr} queue between the instruction cache response and
// decode. Storage is flopped, so the head entry is a registered output.
//
// Ports:
//   clk, rstn      core clock, asynchronous active-low reset
//   push/push_data enqueue one entry at the tail
//   pop            dequeue the head entry (ignored when empty)
//   flush          drop all entries (wins over push/pop)
//   count          number of valid entries (0..2)
//   head_valid     queue not empty
//   head_data      oldest entry; shows RESET_PC/NOP after reset
// -----------------------------------------------------------------------------
module riscv_core_if_fifo
    import riscv_core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
)
(
    input  logic         clk,
    input  logic         rstn,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         flush,
    output logic [1:0]   count,
    output logic         head_valid,
    output fetch_entry_t head_data
);

    fetch_entry_t mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         pop_ok;
    logic         push_ok;

    // A pop on an empty queue is ignored; a push into a full queue is only
    // legal when the head leaves in the same cycle.
    always_comb begin
        pop_ok  = pop & head_valid;
        push_ok = push & ((count != 2'd2) | pop_ok);
    end

    // Storage and pointers. When full, wr_ptr == rd_ptr, so a simultaneous
    // push/pop overwrites the slot being popped, which is exactly the new tail.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mem[0] <= '{pc: RESET_PC, instr: NOP_INSTR};
            mem[1] <= '{pc: RESET_PC, instr: NOP_INSTR};
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop_ok) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    assign head_valid = (count != 2'd0);
    assign head_data  = mem[rd_ptr];

    // The fetch credit scheme guarantees there is always room for a response.
    overflow_check : assert property (
        @(posedge clk) disable iff (!rstn)
        !(push && !flush && !pop_ok && (count == 2'd2))
    );

endmodule

// File: rtl/riscv_core_if.sv
// -----------------------------------------------------------------------------
// riscv_core_if
// Instruction fetch stage. Generates the fetch PC, issues word-aligned
// requests to the instruction cache, buffers returned words in a two-entry
// queue and presents {instr, pc} to decode with a valid/stall handshake.
// Redirects from decode flush the queue and discard in-flight responses.
//
// Optional feature macro: RISCV_CORE_IF_MISALIGN_EN
//   defined     : a redirect to a non-word-aligned target halts fetch and
//                 presents a single misalign marker (NOP, pc = target,
//                 if_id_misalign = 1) until the next redirect.
//   not defined : id_if_target[1:0] is ignored, if_id_misalign is 0.
//
// Ports:
//   clk, rstn              core clock, asynchronous active-low reset
//   if_ic_req/if_ic_addr   fetch request to the cache
//   ic_if_gnt              cache accepted the request this cycle
//   ic_if_rvalid           in-order response valid, icache_rdata = word
//   if_id_valid/instr/pc   instruction presented to decode
//   stall_back             decode not accepting this cycle
//   id_if_mux_cntl         next-PC select (01 = redirect, else sequential)
//   id_if_target           redirect address
//   if_id_misalign         misaligned redirect marker
// -----------------------------------------------------------------------------
module riscv_core_if
    import riscv_core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000
)
(
    input  logic                clk,
    input  logic                rstn,
    output logic                if_ic_req,
    output logic [XLEN-1:0]     if_ic_addr,
    input  logic                ic_if_gnt,
    input  logic                ic_if_rvalid,
    input  logic [INSTR_W-1:0]  icache_rdata,
    output logic                if_id_valid,
    output logic [INSTR_W-1:0]  if_id_instr,
    output logic [XLEN-1:0]     if_id_pc,
    input  logic                stall_back,
    input  logic [1:0]          id_if_mux_cntl,
    input  logic [XLEN-1:0]     id_if_target,
    output logic                if_id_misalign
);

    logic [XLEN-1:0] fetch_pc;
    logic [1:0]      outstanding;
    logic [1:0]      discard;

    // PCs of in-flight requests, oldest at shadow_rd
    logic [XLEN-1:0] pc_shadow [2];
    logic            shadow_wr;
    logic            shadow_rd;

    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            misalign_hold;
    logic            grant;
    logic            resp;
    logic            resp_drop;
    logic            q_push;
    logic            q_pop;
    logic [1:0]      q_count;
    logic            q_valid;
    fetch_entry_t    q_in;
    fetch_entry_t    q_head;
    logic [2:0]      credit_used;

`ifdef RISCV_CORE_IF_MISALIGN_EN
    logic misalign_set;

    assign redirect_pc  = id_if_target;
    assign misalign_set = (id_if_target[1:0] != 2'b00);

    // Every redirect re-decides whether fetch is parked on a misaligned target.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            misalign_hold <= 1'b0;
        end else if (redirect) begin
            misalign_hold <= misalign_set;
        end
    end
`else
    logic unused_target_bits;

    assign redirect_pc        = {id_if_target[XLEN-1:2], 2'b00};
    assign misalign_hold      = 1'b0;
    assign unused_target_bits = ^id_if_target[1:0];
`endif

    // Request/handshake decode. The credit counts the head leaving this
    // cycle as already free, which is what keeps one instruction per cycle
    // flowing when the cache answers in one cycle. Gating with rstn keeps the
    // request low while reset is held and raises it in the first cycle after.
    always_comb begin
        redirect    = is_redirect(id_if_mux_cntl);
        q_pop       = q_valid & ~stall_back & ~redirect & ~misalign_hold;
        credit_used = {1'b0, outstanding} + {1'b0, q_count} - {2'b00, q_pop};
        if_ic_req   = rstn & ~redirect & ~misalign_hold & (credit_used < 3'd2);
        grant       = if_ic_req & ic_if_gnt;
        resp        = ic_if_rvalid & (outstanding != 2'd0);
        resp_drop   = (discard != 2'd0) | redirect | misalign_hold;
        q_push      = resp & ~resp_drop;
        q_in        = '{pc: pc_shadow[shadow_rd], instr: icache_rdata};
    end

    // Fetch PC: a redirect overrides any sequential advance; the +4 wraps
    // naturally at the top of the address space.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fetch_pc <= RESET_VECTOR;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
        end else if (grant) begin
            fetch_pc <= fetch_pc + 32'd4;
        end
    end

    // Outstanding request count and wrong-path discard count. On a redirect
    // everything still in flight after this cycle belongs to the old path,
    // so discard becomes the post-cycle outstanding count (no grant can
    // happen in a redirect cycle).
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            outstanding <= 2'd0;
            discard     <= 2'd0;
        end else begin
            outstanding <= outstanding + {1'b0, grant} - {1'b0, resp};
            if (redirect) begin
                discard <= outstanding - {1'b0, resp};
            end else if (resp && (discard != 2'd0)) begin
                discard <= discard - 2'd1;
            end
        end
    end

    // PC shadow follows request order so each response is tagged with the
    // address that produced it, including discarded ones.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_shadow[0] <= RESET_VECTOR;
            pc_shadow[1] <= RESET_VECTOR;
            shadow_wr    <= 1'b0;
            shadow_rd    <= 1'b0;
        end else begin
            if (grant) begin
                pc_shadow[shadow_wr] <= fetch_pc;
                shadow_wr            <= ~shadow_wr;
            end
            if (resp) begin
                shadow_rd <= ~shadow_rd;
            end
        end
    end

    riscv_core_if_fifo #(
        .RESET_PC (RESET_VECTOR)
    ) u_fifo (
        .clk        (clk),
        .rstn       (rstn),
        .push       (q_push),
        .push_data  (q_in),
        .pop        (q_pop),
        .flush      (redirect),
        .count      (q_count),
        .head_valid (q_valid),
        .head_data  (q_head)
    );

    // While parked on a misaligned target the marker replaces the queue head;
    // fetch_pc still holds that target because no grants occur.
    always_comb begin
        if_ic_addr     = fetch_pc;
        if_id_valid    = misalign_hold | q_valid;
        if_id_instr    = misalign_hold ? NOP_INSTR : q_head.instr;
        if_id_pc       = misalign_hold ? fetch_pc  : q_head.pc;
        if_id_misalign = misalign_hold;
    end

    // A response with nothing outstanding means the cache broke protocol.
    stray_response_check : assert property (
        @(posedge clk) disable iff (!rstn)
        ic_if_rvalid |-> (outstanding != 2'd0)
    );

    credit_check : assert property (
        @(posedge clk) disable iff (!rstn)
        ({1'b0, outstanding} + {1'b0, q_count}) <= 3'd2
    );

endmodule

// File: tb/tb_riscv_core_if.sv
// -----------------------------------------------------------------------------
// tb_riscv_core_if
// Randomised bench for the fetch stage. A transaction-level model tracks the
// cache's in-flight requests (tagged with a path epoch), the instructions
// ready for decode and the next fetch address; a negedge process compares the
// DUT against it every cycle. Directed phases pin reset values, throughput,
// redirect latency and address wrap with literal expectations.
// -----------------------------------------------------------------------------
module tb_riscv_core_if;
    import riscv_core_pkg::*;

    localparam logic [31:0] KEY = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        if_ic_req;
    logic [31:0] if_ic_addr;
    logic        ic_if_gnt = 1'b0;
    logic        ic_if_rvalid = 1'b0;
    logic [31:0] icache_rdata = 32'h0;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic        stall_back = 1'b0;
    logic [1:0]  id_if_mux_cntl = 2'b00;
    logic [31:0] id_if_target = 32'h0;
    logic        if_id_misalign;

    riscv_core_if #(.RESET_VECTOR(32'h0000_0000)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .if_ic_req      (if_ic_req),
        .if_ic_addr     (if_ic_addr),
        .ic_if_gnt      (ic_if_gnt),
        .ic_if_rvalid   (ic_if_rvalid),
        .icache_rdata   (icache_rdata),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .stall_back     (stall_back),
        .id_if_mux_cntl (id_if_mux_cntl),
        .id_if_target   (id_if_target),
        .if_id_misalign (if_id_misalign)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [31:0] addr; int epoch; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] instr; } item_t;

    req_t        req_q[$];
    item_t       dq[$];
    logic [31:0] exp_fetch = 32'h0;
    int          epoch = 0;
    bit          mis_hold = 1'b0;
    logic [31:0] mis_pc = 32'h0;
    bit          checking = 1'b0;

    logic [31:0] pop_pc_log[$];
    logic [31:0] pop_instr_log[$];
    int          pop_cyc_log[$];
    logic [31:0] grant_log[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // One cycle of the reference model: compare, then advance to the state
    // that holds after the coming rising edge.
    task automatic modelCycle();
        bit          redir;
        logic [31:0] tgt;
        bit          e_req;
        bit          e_valid;
        bit          pop;
        bit          grant;
        bit          deliver;
        req_t        r;
        redir = (id_if_mux_cntl == 2'b01);
`ifdef RISCV_CORE_IF_MISALIGN_EN
        tgt = id_if_target;
`else
        tgt = {id_if_target[31:2], 2'b00};
`endif
        if (mis_hold) begin
            e_req = 1'b0;
            pop   = 1'b0;
            checkOutput("hold_valid", if_id_valid, 1);
            checkOutput("hold_pc", if_id_pc, mis_pc);
            checkOutput("hold_instr", if_id_instr, NOP_INSTR);
            checkOutput("hold_misalign", if_id_misalign, 1);
        end else begin
            e_valid = (dq.size() != 0);
            pop     = e_valid && !stall_back && !redir;
            e_req   = !redir && ((req_q.size() + dq.size() - int'(pop)) < 2);
            checkOutput("valid", if_id_valid, e_valid);
            if (e_valid) begin
                checkOutput("pc", if_id_pc, dq[0].pc);
                checkOutput("instr", if_id_instr, dq[0].instr);
            end
            checkOutput("misalign", if_id_misalign, 0);
        end
        checkOutput("req", if_ic_req, e_req);
        if (e_req) checkOutput("addr", if_ic_addr, exp_fetch);

        grant   = e_req && ic_if_gnt;
        deliver = 1'b0;
        if (ic_if_rvalid && req_q.size() != 0) begin
            r       = req_q.pop_front();
            deliver = !redir && !mis_hold && (r.epoch == epoch);
        end
        if (pop) begin
            pop_pc_log.push_back(dq[0].pc);
            pop_instr_log.push_back(dq[0].instr);
            pop_cyc_log.push_back(cyc);
            void'(dq.pop_front());
        end
        if (redir) begin
            epoch++;
            dq.delete();
            exp_fetch = tgt;
`ifdef RISCV_CORE_IF_MISALIGN_EN
            mis_hold = (tgt[1:0] != 2'b00);
            mis_pc   = tgt;
`endif
        end else if (deliver) begin
            dq.push_back('{r.addr, r.addr ^ KEY});
        end
        if (grant) begin
            req_q.push_back('{exp_fetch, epoch});
            grant_log.push_back(exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
        end
    endtask

    always @(negedge clk) begin
        if (checking) modelCycle();
    end

    // Drives one cycle of inputs just after the rising edge. The cache only
    // answers when a granted request from an earlier cycle is pending.
    task automatic applyStimulus(input bit stall, input bit redir, input logic [31:0] tgt,
                                 input bit gnt, input bit want_rvalid);
        int v;
        @(posedge clk);
        #1;
        stall_back = stall;
        v = $urandom_range(0, 2);
        if (redir) id_if_mux_cntl = 2'b01;
        else       id_if_mux_cntl = (v == 0) ? 2'b00 : ((v == 1) ? 2'b10 : 2'b11);
        id_if_target = redir ? tgt : $urandom;
        ic_if_gnt    = gnt;
        if (want_rvalid && req_q.size() != 0) begin
            ic_if_rvalid = 1'b1;
            icache_rdata = req_q[0].addr ^ KEY;
        end else begin
            ic_if_rvalid = 1'b0;
            icache_rdata = $urandom;
        end
    endtask

    task automatic sampleNow();
        @(negedge clk);
        #2;
    endtask

    initial begin
        int base;
        int viol;
        logic [31:0] tgt;

        // Reset values
        #12;
        checkOutput("rst_req", if_ic_req, 0);
        checkOutput("rst_addr", if_ic_addr, 32'h0);
        checkOutput("rst_valid", if_id_valid, 0);
        checkOutput("rst_instr", if_id_instr, 32'h0000_0013);
        checkOutput("rst_pc", if_id_pc, 32'h0);
        checkOutput("rst_misalign", if_id_misalign, 0);

        ic_if_gnt = 1'b1;
        @(posedge clk);
        #1;
        rstn     = 1'b1;
        checking = 1'b1;
        sampleNow();
        checkOutput("first_req", if_ic_req, 1);
        checkOutput("first_addr", if_ic_addr, 32'h0);

        // Streaming: one instruction per cycle, pc 0,4,8...
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 1, 1);
        checkOutput("stream_count_ok", pop_pc_log.size() >= 3, 1);
        if (pop_pc_log.size() >= 3) begin
            checkOutput("stream_pc0", pop_pc_log[0], 32'h0);
            checkOutput("stream_pc1", pop_pc_log[1], 32'h4);
            checkOutput("stream_pc2", pop_pc_log[2], 32'h8);
            checkOutput("stream_instr0", pop_instr_log[0], 32'hA5A5_A5A5);
            checkOutput("stream_instr2", pop_instr_log[2], 32'hA5A5_A5AD);
            checkOutput("stream_rate", pop_cyc_log[2] - pop_cyc_log[0], 2);
        end

        // Stall for 5 cycles with the cache ready
        grant_log.delete();
        for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 1, 1);
        checkOutput("stall_grants_bounded", grant_log.size() <= 2, 1);
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 1, 1);
        viol = 0;
        for (int i = 0; i < pop_pc_log.size(); i++)
            if (pop_pc_log[i] != 32'(i * 4)) viol++;
        checkOutput("no_loss_no_dup", viol, 0);

        // Redirect to 0x100 with two responses in flight
        applyStimulus(0, 1, 32'h40, 0, 1);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 1);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 1, 0);
        applyStimulus(0, 1, 32'h100, 0, 1);
        applyStimulus(0, 0, 0, 1, 1);
        sampleNow();
        checkOutput("redir_r1_valid", if_id_valid, 0);
        checkOutput("redir_r1_req", if_ic_req, 1);
        checkOutput("redir_r1_addr", if_ic_addr, 32'h100);
        applyStimulus(0, 0, 0, 1, 1);
        sampleNow();
        checkOutput("redir_r2_valid", if_id_valid, 0);
        applyStimulus(0, 0, 0, 1, 1);
        sampleNow();
        checkOutput("redir_r3_valid", if_id_valid, 1);
        checkOutput("redir_r3_pc", if_id_pc, 32'h100);
        checkOutput("redir_r3_instr", if_id_instr, 32'h100 ^ KEY);

        // Redirect coincident with a response while decode is stalled
        for (int i = 0; i < 3; i++) applyStimulus(1, 0, 0, 1, 1);
        applyStimulus(1, 1, 32'h300, 0, 1);
        applyStimulus(0, 0, 0, 1, 1);
        sampleNow();
        checkOutput("redir_stall_valid", if_id_valid, 0);
        base = pop_pc_log.size();
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 1, 1);
        checkOutput("redir_stall_count_ok", pop_pc_log.size() > base, 1);
        if (pop_pc_log.size() > base) checkOutput("redir_stall_first_pc", pop_pc_log[base], 32'h300);

        // Address wrap
        applyStimulus(0, 1, 32'hFFFF_FFF8, 0, 1);
        grant_log.delete();
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, 0, 1, 1);
        checkOutput("wrap_count_ok", grant_log.size() >= 3, 1);
        if (grant_log.size() >= 3) begin
            checkOutput("wrap_g0", grant_log[0], 32'hFFFF_FFF8);
            checkOutput("wrap_g1", grant_log[1], 32'hFFFF_FFFC);
            checkOutput("wrap_g2", grant_log[2], 32'h0000_0000);
        end

`ifdef RISCV_CORE_IF_MISALIGN_EN
        // Misaligned redirect parks fetch until the next redirect
        applyStimulus(0, 1, 32'h102, 1, 1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 1, 1);
            sampleNow();
            checkOutput("mis_req", if_ic_req, 0);
            checkOutput("mis_flag", if_id_misalign, 1);
            checkOutput("mis_valid", if_id_valid, 1);
            checkOutput("mis_pc", if_id_pc, 32'h102);
            checkOutput("mis_instr", if_id_instr, 32'h0000_0013);
        end
        applyStimulus(0, 1, 32'h200, 1, 1);
        applyStimulus(0, 0, 0, 1, 1);
        sampleNow();
        checkOutput("mis_resume_req", if_ic_req, 1);
        checkOutput("mis_resume_addr", if_ic_addr, 32'h200);
        checkOutput("mis_resume_flag", if_id_misalign, 0);
`else
        // Low target bits are ignored
        applyStimulus(0, 1, 32'h102, 1, 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 1, 1);
        sampleNow();
        checkOutput("align_flag", if_id_misalign, 0);
        checkOutput("align_seen", (grant_log[grant_log.size()-1] & 32'hFFFF_FF00) == 32'h100, 1);
`endif

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            bit rd;
            rd  = ($urandom_range(0, 99) < 5);
            tgt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hC);
`ifdef RISCV_CORE_IF_MISALIGN_EN
            if ($urandom_range(0, 19) == 0) tgt = tgt | 32'($urandom_range(1, 3));
`endif
            applyStimulus($urandom_range(0, 99) < 30, rd, tgt,
                          $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 60);
        end
        for (int i = 0; i < 6; i++) applyStimulus(0, 0, 0, 0, 1);
        sampleNow();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/riscv_core_if.md
# riscv_core_if

Instruction fetch stage of the RISC-V core. Generates the fetch PC, issues requests to the instruction cache, buffers returned instructions in a 2-entry queue and presents {instr, pc} to the decode stage with a valid/stall handshake. It accepts redirects from decode, flushes wrong-path state and discards in-flight wrong-path responses.

## Interface
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset
- clk  in  1  core clock
- rstn  in  1  reset; one clock; reset is asynchronous and active-low
- if_ic_req  out  1  fetch request valid
- if_ic_addr  out  32  fetch address, word aligned
- ic_if_gnt  in  1  request accepted this cycle (ignored when if_ic_req=0)
- ic_if_rvalid  in  1  response valid; responses in request order, earliest 1 cycle after grant
- icache_rdata  in  32  response instruction word
- if_id_valid  out  1  instruction available to decode
- if_id_instr  out  32  instruction word
- if_id_pc  out  32  PC of if_id_instr
- stall_back  in  1  decode not accepting; transfer when if_id_valid & !stall_back
- id_if_mux_cntl  in  2  next-PC select: 2'b00 sequential, 2'b01 redirect to id_if_target, 2'b1x treated as 2'b00
- id_if_target  in  32  redirect address
- if_id_misalign  out  1  misaligned redirect flag (see Configuration)

## Operation
- State: fetch_pc (32), outstanding (0..2), discard (0..2), 2-entry queue of {pc, instr}.
- Credit: if_ic_req=1 when outstanding + queue_count < 2 and no redirect this cycle; if_ic_addr=fetch_pc. Non-granted requests may change or drop next cycle (no hold rule).
- Grant: fetch_pc += 4 (wraps mod 2^32), outstanding += 1.
- Response: outstanding -= 1; if discard>0 then discard -= 1 and data dropped, else {pc, icache_rdata} pushed to queue. Response PC tracked by a 2-entry PC shadow in request order.
- Grant and response in the same cycle: outstanding unchanged.
- Redirect (id_if_mux_cntl=2'b01): fetch_pc <= id_if_target; queue flushed; discard <= outstanding minus any non-discarded response arriving this cycle (that response also dropped); if_ic_req forced 0 this cycle. Redirect has priority over stall and over a queue pop.
- Pop: if_id_valid & !stall_back removes head. Queue never overflows by credit rule; overflow is an assertion failure.
- Reset values: if_ic_req=0, if_ic_addr=RESET_VECTOR, if_id_valid=0, if_id_instr=32'h0000_0013, if_id_pc=RESET_VECTOR, if_id_misalign=0; fetch_pc=RESET_VECTOR, counters 0, queue empty. Reset mid-operation drops all state; later stray ic_if_rvalid is a cache protocol violation.

## Timing
- First if_ic_req in first cycle after rstn deasserts (combinational from reset state).
- Grant cycle N, response N+k (k≥1), if_id_valid at N+k+1 (queue output registered).
- Redirect in cycle R: if_id_valid=0 at R+1; new request at R+1; first new-path instruction earliest R+3.
- Full throughput: with k=1 and no stall, one instruction per cycle steady state.
- stall_back holds if_id_* stable; fetch continues until credit exhausted.

## Configuration
- RISCV_CORE_IF_MISALIGN_EN defined: redirect with id_if_target[1:0]!=0 stops fetching, flushes as normal, then presents if_id_valid=1, if_id_misalign=1, if_id_pc=id_if_target, if_id_instr=32'h0000_0013 held until next redirect; in-flight responses still discarded.
- Not defined: id_if_target[1:0] forced to 2'b00, if_id_misalign tied 0.

## Structure
- Shared package riscv_core_pkg: next-PC select encodings (sequential/redirect), NOP constant 32'h0000_0013, instruction width.
- Sub-module riscv_core_if_fifo: 2-entry {pc, instr} queue with push, pop, flush, count, registered head output.

## Test plan
- Reset release, ic_if_gnt=1, rvalid one cycle after each grant, rdata=addr^32'hA5A5_A5A5 -> if_id_pc 0x0,0x4,0x8… one per cycle, instr matching.
- stall_back=1 for 5 cycles with cache ready -> at most 2 requests outstanding+queued, if_id_* stable, no loss or duplication after release.
- Redirect to 0x100 with 2 responses in flight -> both dropped, next delivered if_id_pc=0x100 at R+3 earliest.
- Redirect coincident with rvalid and stall_back=1 -> that response dropped, if_id_valid=0 at R+1.
- fetch_pc=32'hFFFF_FFFC sequential -> next if_ic_addr=0x0.
- With RISCV_CORE_IF_MISALIGN_EN, redirect to 0x102 -> if_ic_req stays 0, if_id_misalign=1, if_id_pc=0x102; redirect to 0x200 resumes fetch.
